// File: rtl/cond_pkg.sv
// Shared definitions for ARM condition evaluation and IT-block predication.
package cond_pkg;

  typedef enum logic [3:0] {
    CC_EQ = 4'h0, CC_NE, CC_CS, CC_CC, CC_MI, CC_PL, CC_VS, CC_VC,
    CC_HI, CC_LS, CC_GE, CC_LT, CC_GT, CC_LE, CC_AL, CC_NV
  } cond_e;

  typedef enum logic {IT_IDLE = 1'b0, IT_ACTIVE = 1'b1} it_state_t;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  // AL has no inverse encoding, so it stays AL in the "else" slots.
  function automatic logic [3:0] cond_invert(input logic [3:0] c);
    return (c == CC_AL) ? c : {c[3:1], ~c[0]};
  endfunction

endpackage

// File: rtl/cond_en_flop.sv
// Enable flop with asynchronous active-low clear; one instance per flag group.
module cond_en_flop #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)  q <= '0;
    else if (en) q <= d;
  end

endmodule

// File: rtl/condcheck_p.sv
// Combinational ARM condition evaluator: cond + NZCV -> pass.
module condcheck_p
  import cond_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       pass
);

  logic n, z, c, v;

  always_comb begin
    n    = flags[FLAG_N];
    z    = flags[FLAG_Z];
    c    = flags[FLAG_C];
    v    = flags[FLAG_V];
    pass = 1'b0;
    case (cond)
      CC_EQ: pass = z;
      CC_NE: pass = ~z;
      CC_CS: pass = c;
      CC_CC: pass = ~c;
      CC_MI: pass = n;
      CC_PL: pass = ~n;
      CC_VS: pass = v;
      CC_VC: pass = ~v;
      CC_HI: pass = c & ~z;
      CC_LS: pass = ~c | z;
      CC_GE: pass = (n == v);
      CC_LT: pass = (n != v);
      CC_GT: pass = ~z & (n == v);
      CC_LE: pass = z | (n != v);
      CC_AL: pass = 1'b1;
      default: pass = 1'b0;
    endcase
  end

endmodule

// File: rtl/condlogic_it.sv
// Conditional-execution unit: NZCV register, condition gating and IT-block
// predication with stall/flush qualification and optional output register.
module condlogic_it
  import cond_pkg::*;
#(
  parameter int FLAG_GROUPS = 2,
  parameter int ITDEPTH     = 4,
  parameter int OUT_REG     = 0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         valid,
  input  logic                         stall,
  input  logic                         flush,
  input  logic [3:0]                   Cond,
  input  logic [3:0]                   ALUFlags,
  input  logic [FLAG_GROUPS-1:0]       FlagW,
  input  logic                         PCS,
  input  logic                         RegW,
  input  logic                         MemW,
  input  logic                         ItStart,
  input  logic [$clog2(ITDEPTH+1)-1:0] ItLen,
  input  logic [ITDEPTH-1:0]           ItMask,
  output logic                         PCSrc,
  output logic                         RegWrite,
  output logic                         MemWrite,
  output logic                         CondEx,
  output logic [3:0]                   Flags,
  output logic                         ItActive
);

  localparam int LEN_W  = $clog2(ITDEPTH+1);
  localparam int SLOT_W = (ITDEPTH > 1) ? $clog2(ITDEPTH) : 1;
  localparam int GW     = 4 / FLAG_GROUPS;

  it_state_t          state_q, state_d;
  logic [3:0]         base_q, base_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [ITDEPTH-1:0] mask_q, mask_d;
  logic [SLOT_W-1:0]  slot_q, slot_d;

  logic       accept, it_active, it_instr, pass, cond_ex, exec_ok, taken, last_slot;
  logic [3:0] eff_cond, out_d, out_c;
  logic [FLAG_GROUPS-1:0] flag_we;

  // Reset also masks the combinational outputs so they drop immediately.
  assign accept    = reset & valid & ~stall & ~flush;
  assign it_active = (state_q == IT_ACTIVE);
  assign it_instr  = ItStart & ~it_active;
  assign last_slot = (int'(slot_q) + 1 == int'(len_q));

  always_comb begin
    eff_cond = Cond;
    if (it_active) eff_cond = mask_q[slot_q] ? base_q : cond_invert(base_q);
  end

  condcheck_p u_check (.cond(eff_cond), .flags(Flags), .pass(pass));

  // The IT instruction reports its own condition but never executes anything.
  always_comb begin
    cond_ex = 1'b0;
    exec_ok = 1'b0;
    if (accept) begin
      if (it_instr) begin
        cond_ex = (Cond != CC_NV);
      end else begin
        cond_ex = pass;
        exec_ok = pass;
      end
    end
  end

  assign taken   = exec_ok & PCS;
  assign flag_we = {FLAG_GROUPS{exec_ok}} & FlagW;

  for (genvar g = 0; g < FLAG_GROUPS; g++) begin : g_flag
    cond_en_flop #(.W(GW)) u_flag (
      .clk  (clk),
      .reset(reset),
      .en   (flag_we[g]),
      .d    (ALUFlags[GW*g +: GW]),
      .q    (Flags[GW*g +: GW])
    );
  end

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    len_d   = len_q;
    mask_d  = mask_q;
    slot_d  = slot_q;
    if (flush) begin
      state_d = IT_IDLE;
      slot_d  = '0;
    end else if (accept) begin
      if (!it_active) begin
        if (ItStart && ItLen != '0 && int'(ItLen) <= ITDEPTH) begin
          state_d = IT_ACTIVE;
          base_d  = Cond;
          len_d   = ItLen;
          mask_d  = ItMask;
          slot_d  = '0;
        end
      end else if (last_slot || taken) begin
        state_d = IT_IDLE;
        slot_d  = '0;
      end else begin
        slot_d = slot_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IT_IDLE;
      base_q  <= '0;
      len_q   <= '0;
      mask_q  <= '0;
      slot_q  <= '0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      len_q   <= len_d;
      mask_q  <= mask_d;
      slot_q  <= slot_d;
    end
  end

  assign ItActive = it_active;
  assign out_d    = {cond_ex, PCS & exec_ok, RegW & exec_ok, MemW & exec_ok};

  if (OUT_REG != 0) begin : g_oreg
    logic [3:0] out_q;
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) out_q <= '0;
      else        out_q <= out_d;
    end
    assign out_c = out_q;
  end else begin : g_ocomb
    assign out_c = out_d;
  end

  assign {CondEx, PCSrc, RegWrite, MemWrite} = out_c;

endmodule

// File: tb/tb_condlogic_it.sv
// Directed bench: combinational and registered-output variants driven in parallel.
module tb_condlogic_it;

  localparam logic [3:0] EQ = 4'h0, NE = 4'h1, CS = 4'h2, CC = 4'h3, MI = 4'h4;
  localparam logic [3:0] GE = 4'hA, LT = 4'hB, HI = 4'h8, AL = 4'hE, NV = 4'hF;

  logic       clk = 1'b0;
  logic       reset, valid, stall, flush, PCS, RegW, MemW, ItStart;
  logic [3:0] Cond, ALUFlags, ItMask;
  logic [1:0] FlagW;
  logic [2:0] ItLen;

  logic       PCSrc0, RegWrite0, MemWrite0, CondEx0, ItActive0;
  logic       PCSrc1, RegWrite1, MemWrite1, CondEx1, ItActive1;
  logic [3:0] Flags0, Flags1;

  int total = 0;
  int bad   = 0;
  logic [3:0] prev4 = 4'b0000;

  always #5 clk = ~clk;

  condlogic_it #(.FLAG_GROUPS(2), .ITDEPTH(4), .OUT_REG(0)) dut0 (
    .clk(clk), .reset(reset), .valid(valid), .stall(stall), .flush(flush),
    .Cond(Cond), .ALUFlags(ALUFlags), .FlagW(FlagW), .PCS(PCS), .RegW(RegW),
    .MemW(MemW), .ItStart(ItStart), .ItLen(ItLen), .ItMask(ItMask),
    .PCSrc(PCSrc0), .RegWrite(RegWrite0), .MemWrite(MemWrite0), .CondEx(CondEx0),
    .Flags(Flags0), .ItActive(ItActive0)
  );

  condlogic_it #(.FLAG_GROUPS(2), .ITDEPTH(4), .OUT_REG(1)) dut1 (
    .clk(clk), .reset(reset), .valid(valid), .stall(stall), .flush(flush),
    .Cond(Cond), .ALUFlags(ALUFlags), .FlagW(FlagW), .PCS(PCS), .RegW(RegW),
    .MemW(MemW), .ItStart(ItStart), .ItLen(ItLen), .ItMask(ItMask),
    .PCSrc(PCSrc1), .RegWrite(RegWrite1), .MemWrite(MemWrite1), .CondEx(CondEx1),
    .Flags(Flags1), .ItActive(ItActive1)
  );

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic ins(input logic v, input logic st, input logic fl, input logic [3:0] c,
                     input logic [3:0] af, input logic [1:0] fw,
                     input logic p, input logic rw, input logic mw);
    valid = v; stall = st; flush = fl; Cond = c; ALUFlags = af; FlagW = fw;
    PCS = p; RegW = rw; MemW = mw; ItStart = 1'b0; ItLen = 3'd0; ItMask = 4'b0000;
  endtask

  // e_out is {CondEx, PCSrc, RegWrite, MemWrite} of the combinational variant;
  // the registered variant must show the previous cycle's e_out.
  task automatic cyc(input string tag, input logic [3:0] e_out,
                     input logic [3:0] e_flags, input logic e_it);
    @(negedge clk);
    chk({tag, ".out0"}, {CondEx0, PCSrc0, RegWrite0, MemWrite0}, e_out);
    chk({tag, ".out1"}, {CondEx1, PCSrc1, RegWrite1, MemWrite1}, prev4);
    chk({tag, ".flags0"}, Flags0, e_flags);
    chk({tag, ".flags1"}, Flags1, e_flags);
    chk({tag, ".itact"}, {2'b00, ItActive0, ItActive1}, {2'b00, e_it, e_it});
    prev4 = e_out;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0;
    ins(0, 0, 0, EQ, 4'b0000, 2'b00, 0, 0, 0);
    cyc("rst", 4'b0000, 4'b0000, 1'b0);
    reset = 1'b1;

    ins(1, 0, 0, AL, 4'b0100, 2'b10, 0, 0, 0); cyc("setz",   4'b1000, 4'b0000, 1'b0);
    ins(1, 0, 0, EQ, 4'b0000, 2'b00, 0, 1, 1); cyc("eq",     4'b1011, 4'b0100, 1'b0);
    ins(1, 0, 0, NE, 4'b0000, 2'b00, 0, 1, 1); cyc("ne",     4'b0000, 4'b0100, 1'b0);
    ins(1, 0, 0, NV, 4'b0000, 2'b00, 0, 1, 1); cyc("nv",     4'b0000, 4'b0100, 1'b0);
    ins(0, 0, 0, EQ, 4'b0000, 2'b00, 0, 1, 0); cyc("nvalid", 4'b0000, 4'b0100, 1'b0);
    ins(1, 0, 0, AL, 4'b0000, 2'b11, 0, 0, 0); cyc("clr",    4'b1000, 4'b0100, 1'b0);
    ins(1, 0, 0, AL, 4'b1111, 2'b01, 0, 0, 0); cyc("fw01",   4'b1000, 4'b0000, 1'b0);
    ins(1, 0, 0, EQ, 4'b0000, 2'b11, 0, 1, 0); cyc("failfw", 4'b0000, 4'b0011, 1'b0);
    ins(1, 0, 0, CS, 4'b0000, 2'b01, 0, 1, 0); cyc("cs",     4'b1010, 4'b0011, 1'b0);
    ins(1, 0, 0, CC, 4'b0000, 2'b00, 0, 1, 0); cyc("cc",     4'b1010, 4'b0000, 1'b0);
    ins(1, 0, 0, AL, 4'b1000, 2'b10, 0, 0, 0); cyc("setn",   4'b1000, 4'b0000, 1'b0);
    ins(1, 0, 0, LT, 4'b0000, 2'b00, 0, 1, 0); cyc("lt",     4'b1010, 4'b1000, 1'b0);
    ins(1, 0, 0, GE, 4'b0000, 2'b00, 0, 1, 0); cyc("ge",     4'b0000, 4'b1000, 1'b0);
    ins(1, 0, 0, MI, 4'b0000, 2'b00, 0, 0, 1); cyc("mi",     4'b1001, 4'b1000, 1'b0);
    ins(1, 0, 0, HI, 4'b0000, 2'b00, 0, 1, 0); cyc("hi",     4'b0000, 4'b1000, 1'b0);
    ins(1, 0, 0, AL, 4'b0100, 2'b11, 0, 0, 0); cyc("setz2",  4'b1000, 4'b1000, 1'b0);

    // IT EQ, 3 slots, mask 101 -> pass, fail, pass with Z=1
    ins(1, 0, 0, EQ, 4'b0000, 2'b00, 0, 1, 1);
    ItStart = 1'b1; ItLen = 3'd3; ItMask = 4'b0101;
    cyc("it1", 4'b1000, 4'b0100, 1'b0);
    ins(1, 0, 0, NE, 4'b0000, 2'b00, 0, 1, 0); cyc("it1.s0", 4'b1010, 4'b0100, 1'b1);
    ins(1, 0, 0, NE, 4'b0000, 2'b00, 0, 1, 0); cyc("it1.s1", 4'b0000, 4'b0100, 1'b1);
    ins(1, 0, 0, NE, 4'b0000, 2'b00, 0, 1, 0); cyc("it1.s2", 4'b1010, 4'b0100, 1'b1);
    ins(1, 0, 0, NE, 4'b0000, 2'b00, 0, 1, 0); cyc("it1.end", 4'b0000, 4'b0100, 1'b0);

    // IT EQ, mask 010, stalled twice on slot 1, then flush+stall in slot 2
    ins(1, 0, 0, EQ, 4'b0000, 2'b00, 0, 0, 0);
    ItStart = 1'b1; ItLen = 3'd3; ItMask = 4'b0010;
    cyc("it2", 4'b1000, 4'b0100, 1'b0);
    ins(1, 0, 0, AL, 4'b0000, 2'b00, 0, 1, 0); cyc("it2.s0",  4'b0000, 4'b0100, 1'b1);
    ins(1, 1, 0, AL, 4'b0000, 2'b11, 0, 1, 0); cyc("it2.st1", 4'b0000, 4'b0100, 1'b1);
    ins(1, 1, 0, AL, 4'b0000, 2'b11, 0, 1, 0); cyc("it2.st2", 4'b0000, 4'b0100, 1'b1);
    ins(1, 0, 0, AL, 4'b0000, 2'b00, 0, 1, 0); cyc("it2.s1",  4'b1010, 4'b0100, 1'b1);
    ins(1, 1, 1, AL, 4'b0000, 2'b11, 0, 1, 0); cyc("it2.fl",  4'b0000, 4'b0100, 1'b1);
    ins(1, 0, 0, EQ, 4'b0000, 2'b00, 0, 1, 0); cyc("it2.end", 4'b1010, 4'b0100, 1'b0);

    // IT AL, 4 slots, mask 0000 (AL never inverted), taken branch in slot 0
    ins(1, 0, 0, AL, 4'b0000, 2'b00, 1, 1, 0);
    ItStart = 1'b1; ItLen = 3'd4; ItMask = 4'b0000;
    cyc("it3", 4'b1000, 4'b0100, 1'b0);
    ins(1, 0, 0, NE, 4'b0000, 2'b00, 1, 0, 0); cyc("it3.br",  4'b1100, 4'b0100, 1'b1);
    ins(1, 0, 0, NE, 4'b0000, 2'b00, 0, 1, 0); cyc("it3.end", 4'b0000, 4'b0100, 1'b0);

    // Reset asserted mid-block
    ins(1, 0, 0, EQ, 4'b0000, 2'b00, 0, 0, 0);
    ItStart = 1'b1; ItLen = 3'd2; ItMask = 4'b0011;
    cyc("it4", 4'b1000, 4'b0100, 1'b0);
    ins(1, 0, 0, NE, 4'b0000, 2'b00, 0, 1, 0); cyc("it4.s0", 4'b1010, 4'b0100, 1'b1);
    ins(1, 0, 0, NE, 4'b0000, 2'b00, 0, 1, 0);
    reset = 1'b0;
    prev4 = 4'b0000;
    cyc("rstmid", 4'b0000, 4'b0000, 1'b0);
    reset = 1'b1;
    ins(1, 0, 0, EQ, 4'b0000, 2'b00, 0, 1, 0); cyc("postrst", 4'b0000, 4'b0000, 1'b0);
    ins(1, 0, 0, AL, 4'b0000, 2'b00, 0, 1, 1); cyc("alive",   4'b1011, 4'b0000, 1'b0);
    ins(0, 0, 0, AL, 4'b0000, 2'b00, 0, 0, 0); cyc("idle",    4'b0000, 4'b0000, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/condlogic_it.md
# condlogic_it

Parametrised conditional-execution unit for the ARM control unit, successor to the single-cycle condition logic. It holds the NZCV flag register in independently writable groups, evaluates the 4-bit ARM condition field, gates PCSrc/RegWrite/MemWrite, and adds an IT-block predication engine. That engine applies a stored base condition, or its inverse, to up to ITDEPTH following instructions. It also adds pipeline stall/flush qualification and an optional registered output stage.

## Interface
Parameters:
- FLAG_GROUPS, 2: number of independently written flag groups; must divide 4 (1, 2 or 4). FlagW bit g enables flags [4/FLAG_GROUPS*(g+1)-1 : 4/FLAG_GROUPS*g].
- ITDEPTH, 4: maximum instructions covered by one IT block (1..8).
- OUT_REG, 0: 0 = gated outputs combinational (latency 0); 1 = gated outputs registered (latency 1).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low; clears all state.
- valid  in  1  an instruction is presented this cycle.
- stall  in  1  hold: no state update, outputs forced 0.
- flush  in  1  kill current instruction and any IT block in progress.
- Cond  in  4  ARM condition field (NZCV order: Flags[3]=N, [2]=Z, [1]=C, [0]=V).
- ALUFlags  in  4  flags produced by the ALU this cycle.
- FlagW  in  FLAG_GROUPS  requested per-group flag write.
- PCS, RegW, MemW  in  1 each  ungated control requests.
- ItStart  in  1  current instruction is an IT instruction.
- ItLen  in  $clog2(ITDEPTH+1)  number of predicated instructions (1..ITDEPTH).
- ItMask  in  ITDEPTH  bit i=1: slot i uses base condition; 0: inverted.
- PCSrc, RegWrite, MemWrite  out  1 each  gated controls.
- CondEx  out  1  effective condition passed.
- Flags  out  4  current flag register.
- ItActive  out  1  IT block in progress.

## Operation
- Accept = valid & ~stall & ~flush.
- Effective condition: if ItActive, the stored base condition when ItMask_q[slot]=1, else the base condition with bit 0 inverted. Exception: base 4'b1110 (AL) is never inverted. Otherwise the effective condition is Cond.
- Condition check: standard ARM table (EQ..AL). 4'b1111 evaluates false.
- CondEx = accept & check(effective cond, Flags).
- PCSrc/RegWrite/MemWrite = request & CondEx.
- Flag group g written with ALUFlags slice when CondEx & FlagW[g].
- IT FSM states: IDLE, ACTIVE.
  - IDLE -> ACTIVE on accepted ItStart with ItLen≠0. Captures base=Cond, len=ItLen, mask=ItMask, slot=0.
  - The IT instruction itself: CondEx=1 if Cond≠4'b1111, with all gated outputs 0 and no flag write.
  - ItLen=0 or ItLen>ITDEPTH: ignored, stays IDLE.
  - ACTIVE: each accepted instruction consumes one slot, whether it passes or fails. slot increments; on slot==len-1 -> IDLE.
  - ItStart while ACTIVE: treated as an ordinary predicated instruction, consumes a slot, does not reload.
  - Accepted PCS that passes inside ACTIVE (taken branch): IT block terminates -> IDLE next edge.
  - flush in any state -> IDLE next edge; the current instruction is dropped.
  - stall: FSM, slot, flags frozen.

## Timing
- Reset values: Flags=4'b0000, ItActive=0, FSM IDLE, slot=0, all gated outputs 0 (including the OUT_REG stage).
- OUT_REG=0: PCSrc/RegWrite/MemWrite/CondEx valid same cycle as inputs. OUT_REG=1: one cycle later; the register captures 0 when not accepted.
- Flags and IT state update on the rising edge after accept. An instruction sees flags written by the previous accepted instruction, not its own.
- ItActive rises the cycle after the IT instruction and falls the cycle after the last slot, flush, or taken branch.
- Simultaneous flush+stall: flush wins.
- Reset mid-IT-block: immediately IDLE, flags cleared.

## Structure
- Shared package cond_pkg: condition code enum (EQ..NV), it_state_t enum, NZCV bit index constants, function cond_invert().
- One sub-module: condcheck_p (purely combinational condition evaluator, cond + flags -> pass). It is reused by the future pipelined datapath.
- Flag register built as FLAG_GROUPS instances of a parametrised enable flop with async active-low reset.

## Test plan
- Flags=Z set (4'b0100): Cond=EQ, RegW=1, MemW=1 -> RegWrite=1, MemWrite=1. Cond=NE -> both 0. Cond=4'b1111 -> 0.
- FLAG_GROUPS=2: FlagW=2'b01, ALUFlags=4'b1111 from Flags=0 -> Flags=4'b0011 next cycle. A failing CondEx with FlagW=2'b11 leaves Flags unchanged.
- IT: Cond=EQ, ItLen=3, ItMask=3'b101, Flags Z=1. Next three instructions -> CondEx=1,0,1. ItActive high for exactly 3 accepted cycles.
- IT block with stall on slot 1 for 2 cycles: slot held, outputs 0 during stall. Completes after 3 accepted instructions. Flush in slot 2 -> ItActive=0 next cycle.
- Taken branch (PCS=1, pass) in slot 0 of ItLen=4 -> PCSrc=1, ItActive=0 next cycle.
- OUT_REG=1: each of the above responses appears exactly one cycle later. reset asserted mid-block -> all outputs 0 asynchronously, Flags=0.
